// File: rtl/date_pkg.sv
// Shared constants and types for the calendar path: seconds-per-unit
// constants, time-of-day field widths and the time-of-day rebuild states.
package date_pkg;

  localparam int unsigned TIME_W      = 32;
  localparam int unsigned SEC_IN_DAY  = 86400;
  localparam int unsigned SEC_IN_HOUR = 3600;
  localparam int unsigned SEC_IN_MIN  = 60;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  // Seconds-of-day (0..86399) needs 17 bits.
  localparam int unsigned SOD_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    HRS,
    MINS
  } tod_conv_state_t;

endpackage

// File: rtl/sec_of_day_div.sv
// Sequential restoring-division remainder unit: 32-bit dividend modulo a
// constant divisor that fits in SOD_W bits. One quotient bit per cycle; the
// first bit is resolved on the start edge, so the remainder is ready
// (done_o=1) 31 cycles after the start edge. done_o stays high until the
// next start.
module sec_of_day_div
  import date_pkg::*;
#(
  parameter int unsigned DIVISOR = SEC_IN_DAY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [TIME_W-1:0] dividend_i,
  output logic              done_o,
  output logic [SOD_W-1:0]  rem_o
);

  if (DIVISOR == 0 || DIVISOR >= (2 ** SOD_W)) begin : g_divisor_check
    $error("sec_of_day_div: DIVISOR must be in 1..2**SOD_W-1");
  end

  localparam int unsigned     CNT_W       = $clog2(TIME_W);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIME_W - 1);
  localparam logic [SOD_W:0]  DIVISOR_EXT = (SOD_W + 1)'(DIVISOR);

  logic [TIME_W-1:0] dvd_q,  dvd_d;
  logic [SOD_W-1:0]  rem_q,  rem_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [SOD_W-1:0] rem_step(input logic [SOD_W-1:0] rem,
                                                input logic             bit_in);
    logic [SOD_W:0] trial;
    trial = {rem, bit_in};
    if (trial >= DIVISOR_EXT) begin
      trial = trial - DIVISOR_EXT;
    end
    return trial[SOD_W-1:0];
  endfunction

  // Load on start (resolving the MSB immediately), then one bit per cycle.
  always_comb begin
    // NOTE: every _d starts from its held value so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    if (start_i) begin
      rem_d  = rem_step('0, dividend_i[TIME_W-1]);
      dvd_d  = {dividend_i[TIME_W-2:0], 1'b0};
      cnt_d  = CNT_W'(1);
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      rem_d = rem_step(rem_q, dvd_q[TIME_W-1]);
      dvd_d = {dvd_q[TIME_W-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Division state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/posix_time_counter.sv
// Free-running POSIX seconds counter with a 1 Hz prescaler, an hh:mm:ss
// time-of-day kept in step with it, and a valid/ready set port. A loaded
// value is broken into hh:mm:ss by a seconds-of-day divider followed by
// repeated hour and minute subtraction.
module posix_time_counter
  import date_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_valid_i,
  input  logic [TIME_W-1:0] set_time_i,
  output logic              set_ready_o,
  output logic [TIME_W-1:0] posix_time_o,
  output logic              sec_tick_o,
  output logic              day_tick_o,
  output logic [HOUR_W-1:0] hour_o,
  output logic [MIN_W-1:0]  min_o,
  output logic [SEC_W-1:0]  sec_o,
  output logic              tod_valid_o
);

  // The rebuild takes at most 117 cycles; a prescaler period of at least 128
  // guarantees no tick arrives before it finishes.
  if (CLK_FREQ_HZ < 128) begin : g_freq_check
    $error("posix_time_counter: CLK_FREQ_HZ must be >= 128");
  end

  localparam int unsigned        PRESC_W   = $clog2(CLK_FREQ_HZ);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);

  localparam logic [SOD_W-1:0]  HOUR_SECS = SOD_W'(SEC_IN_HOUR);
  localparam logic [SOD_W-1:0]  MIN_SECS  = SOD_W'(SEC_IN_MIN);
  localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(23);
  localparam logic [MIN_W-1:0]  LAST_MIN  = MIN_W'(59);
  localparam logic [SEC_W-1:0]  LAST_SEC  = SEC_W'(59);

  tod_conv_state_t   state_q,     state_d;
  logic [PRESC_W-1:0] presc_q,    presc_d;
  logic [TIME_W-1:0] posix_q,     posix_d;
  logic              sec_tick_q,  sec_tick_d;
  logic              day_tick_q,  day_tick_d;
  logic [HOUR_W-1:0] hour_q,      hour_d;
  logic [MIN_W-1:0]  min_q,       min_d;
  logic [SEC_W-1:0]  sec_q,       sec_d;
  logic              ready_q,     ready_d;
  logic              tod_valid_q, tod_valid_d;
  logic [SOD_W-1:0]  conv_rem_q,  conv_rem_d;
  logic [HOUR_W-1:0] conv_hour_q, conv_hour_d;
  logic [MIN_W-1:0]  conv_min_q,  conv_min_d;

  logic             set_accept;
  logic             presc_tc;
  logic             sec_tick_en;
  logic             div_done;
  logic [SOD_W-1:0] div_rem;

  assign set_accept  = set_valid_i & ready_q;
  assign presc_tc    = (presc_q == PRESC_MAX);
  // A set on the terminal-count cycle takes priority and the tick is dropped.
  assign sec_tick_en = presc_tc & (state_q == IDLE) & ~set_accept;

  sec_of_day_div #(
    .DIVISOR (SEC_IN_DAY)
  ) u_sod_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (set_accept),
    .dividend_i (set_time_i),
    .done_o     (div_done),
    .rem_o      (div_rem)
  );

  // Prescaler, seconds counter and tick pulses.
  always_comb begin
    presc_d    = presc_tc ? '0 : presc_q + 1'b1;
    posix_d    = posix_q;
    sec_tick_d = sec_tick_en;
    day_tick_d = sec_tick_en & (hour_q == LAST_HOUR) & (min_q == LAST_MIN) &
                 (sec_q == LAST_SEC);
    if (set_accept) begin
      presc_d = '0;
      posix_d = set_time_i;
    end else if (sec_tick_en) begin
      posix_d = posix_q + 1'b1;
    end
  end

  // Time-of-day carry chain and the rebuild sequence after a set.
  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    ready_d     = ready_q;
    tod_valid_d = tod_valid_q;
    conv_rem_d  = conv_rem_q;
    conv_hour_d = conv_hour_q;
    conv_min_d  = conv_min_q;

    if (sec_tick_en) begin
      if (sec_q == LAST_SEC) begin
        sec_d = '0;
        if (min_q == LAST_MIN) begin
          min_d  = '0;
          hour_d = (hour_q == LAST_HOUR) ? '0 : hour_q + 1'b1;
        end else begin
          min_d = min_q + 1'b1;
        end
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (set_accept) begin
          state_d     = DIV;
          ready_d     = 1'b0;
          tod_valid_d = 1'b0;
        end
      end
      DIV: begin
        if (div_done) begin
          state_d     = HRS;
          conv_rem_d  = div_rem;
          conv_hour_d = '0;
        end
      end
      HRS: begin
        if (conv_rem_q >= HOUR_SECS) begin
          conv_rem_d  = conv_rem_q - HOUR_SECS;
          conv_hour_d = conv_hour_q + 1'b1;
        end else begin
          state_d    = MINS;
          conv_min_d = '0;
        end
      end
      MINS: begin
        if (conv_rem_q >= MIN_SECS) begin
          conv_rem_d = conv_rem_q - MIN_SECS;
          conv_min_d = conv_min_q + 1'b1;
        end else begin
          // Remainder is below 60 here, so it is the seconds field.
          hour_d      = conv_hour_q;
          min_d       = conv_min_q;
          sec_d       = SEC_W'(conv_rem_q);
          state_d     = IDLE;
          ready_d     = 1'b1;
          tod_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and registered outputs; reset lands on the epoch, 00:00:00.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      posix_q     <= '0;
      sec_tick_q  <= 1'b0;
      day_tick_q  <= 1'b0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      ready_q     <= 1'b1;
      tod_valid_q <= 1'b1;
      conv_rem_q  <= '0;
      conv_hour_q <= '0;
      conv_min_q  <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      posix_q     <= posix_d;
      sec_tick_q  <= sec_tick_d;
      day_tick_q  <= day_tick_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      ready_q     <= ready_d;
      tod_valid_q <= tod_valid_d;
      conv_rem_q  <= conv_rem_d;
      conv_hour_q <= conv_hour_d;
      conv_min_q  <= conv_min_d;
    end
  end

  assign set_ready_o  = ready_q;
  assign posix_time_o = posix_q;
  assign sec_tick_o   = sec_tick_q;
  assign day_tick_o   = day_tick_q;
  assign hour_o       = hour_q;
  assign min_o        = min_q;
  assign sec_o        = sec_q;
  assign tod_valid_o  = tod_valid_q;

endmodule

// File: tb/tb_posix_time_counter.sv
// Bench for posix_time_counter at CLK_FREQ_HZ=200. A cycle model works from
// plain arithmetic (seconds-of-day, rebuild latency 34+H+M edges after the
// load edge) and is compared with every output after every clock edge;
// directed sequences add hand-computed literal expectations.
module tb_posix_time_counter;

  localparam int unsigned F = 200;

  logic        clk_i;
  logic        rst_i;
  logic        set_valid_i;
  logic [31:0] set_time_i;
  logic        set_ready_o;
  logic [31:0] posix_time_o;
  logic        sec_tick_o;
  logic        day_tick_o;
  logic [4:0]  hour_o;
  logic [5:0]  min_o;
  logic [5:0]  sec_o;
  logic        tod_valid_o;

  int n_vec = 0;
  int n_err = 0;

  posix_time_counter #(
    .CLK_FREQ_HZ (F)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .set_valid_i  (set_valid_i),
    .set_time_i   (set_time_i),
    .set_ready_o  (set_ready_o),
    .posix_time_o (posix_time_o),
    .sec_tick_o   (sec_tick_o),
    .day_tick_o   (day_tick_o),
    .hour_o       (hour_o),
    .min_o        (min_o),
    .sec_o        (sec_o),
    .tod_valid_o  (tod_valid_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_posix    = '0;
  int unsigned m_presc    = 0;
  int unsigned m_sod      = 0;
  int unsigned m_target   = 0;
  int unsigned m_left     = 0;
  bit          m_busy     = 1'b0;
  bit          m_sec_tick = 1'b0;
  bit          m_day_tick = 1'b0;

  task automatic model_reset();
    m_posix    = '0;
    m_presc    = 0;
    m_sod      = 0;
    m_target   = 0;
    m_left     = 0;
    m_busy     = 1'b0;
    m_sec_tick = 1'b0;
    m_day_tick = 1'b0;
  endtask

  task automatic model_step();
    bit          was_busy;
    bit          accept;
    bit          tc;
    int unsigned h;
    int unsigned m;
    was_busy   = m_busy;
    accept     = set_valid_i && !was_busy;
    tc         = (m_presc == F - 1);
    m_sec_tick = 1'b0;
    m_day_tick = 1'b0;
    if (was_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_sod  = m_target;
      end
    end
    if (accept) begin
      m_posix  = set_time_i;
      m_target = set_time_i % 86400;
      h        = m_target / 3600;
      m        = (m_target % 3600) / 60;
      m_left   = 34 + h + m;
      m_busy   = 1'b1;
      m_presc  = 0;
    end else begin
      m_presc = tc ? 0 : m_presc + 1;
      if (tc && !was_busy) begin
        m_posix    = m_posix + 32'd1;
        m_sod      = (m_sod + 1) % 86400;
        m_sec_tick = 1'b1;
        m_day_tick = (m_sod == 0);
      end
    end
  endtask

  task automatic model_compare();
    check("posix_time", posix_time_o, m_posix);
    check("sec_tick", 32'(sec_tick_o), 32'(m_sec_tick));
    check("day_tick", 32'(day_tick_o), 32'(m_day_tick));
    check("set_ready", 32'(set_ready_o), 32'(!m_busy));
    check("tod_valid", 32'(tod_valid_o), 32'(!m_busy));
    check("hour", 32'(hour_o), m_sod / 3600);
    check("min", 32'(min_o), (m_sod % 3600) / 60);
    check("sec", 32'(sec_o), m_sod % 60);
  endtask

  // Model advances on each edge (or async reset) and is compared 1 ns later.
  always begin
    @(posedge clk_i or posedge rst_i);
    if (rst_i) model_reset();
    else       model_step();
    #1;
    model_compare();
  end

  // ---------------- directed stimulus ----------------
  // Call right after a negedge; the next posedge is the acceptance edge.
  task automatic apply_set(input string name, input logic [31:0] t);
    set_valid_i = 1'b1;
    set_time_i  = t;
    @(posedge clk_i);
    #1;
    check({name, "_loaded"}, posix_time_o, t);
    check({name, "_ready_low"}, 32'(set_ready_o), 0);
    check({name, "_no_tick"}, 32'(sec_tick_o), 0);
    @(negedge clk_i);
    set_valid_i = 1'b0;
  endtask

  task automatic wait_tod_valid(input string name);
    int k;
    k = 0;
    while (!tod_valid_o && k < 300) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    check({name, "_valid_in_time"}, 32'(tod_valid_o), 1);
  endtask

  task automatic check_tod(input string name, input int h, input int m,
                           input int s);
    check({name, "_hour"}, 32'(hour_o), h);
    check({name, "_min"}, 32'(min_o), m);
    check({name, "_sec"}, 32'(sec_o), s);
  endtask

  initial begin
    int ticks;
    int last;
    int bad;
    int got;

    set_valid_i = 1'b0;
    set_time_i  = '0;
    rst_i       = 1'b1;
    repeat (3) @(negedge clk_i);

    // Reset state.
    check("rst_posix", posix_time_o, 0);
    check("rst_ready", 32'(set_ready_o), 1);
    check("rst_tod_valid", 32'(tod_valid_o), 1);
    check("rst_sec_tick", 32'(sec_tick_o), 0);
    check_tod("rst", 0, 0, 0);
    rst_i = 1'b0;

    // Free run for three seconds.
    ticks = 0;
    last  = 0;
    bad   = 0;
    for (int e = 1; e <= 3 * F; e++) begin
      @(posedge clk_i);
      #1;
      if (sec_tick_o) begin
        ticks++;
        if (ticks > 1) check("run_tick_spacing", e - last, F);
        last = e;
      end
      if (!tod_valid_o) bad++;
    end
    check("run_tick_count", ticks, 3);
    check("run_last_tick_edge", last, 3 * F);
    check("run_posix", posix_time_o, 3);
    check("run_sec", 32'(sec_o), 3);
    check("run_valid_drops", bad, 0);

    // Set 1700000000 -> 22:13:20, valid exactly 69 edges after the load edge.
    @(negedge clk_i);
    apply_set("s1700m", 32'd1700000000);
    bad = 0;
    for (int k = 1; k <= 68; k++) begin
      @(posedge clk_i);
      #1;
      if (set_ready_o || tod_valid_o) bad++;
    end
    check("s1700m_busy_window", bad, 0);
    @(posedge clk_i);
    #1;
    check("s1700m_valid_rise", 32'(tod_valid_o), 1);
    check("s1700m_ready_rise", 32'(set_ready_o), 1);
    check_tod("s1700m", 22, 13, 20);

    // Set 86399 -> day rollover 200 cycles later.
    @(negedge clk_i);
    apply_set("s86399", 32'd86399);
    ticks = 0;
    for (int k = 1; k <= F - 1; k++) begin
      @(posedge clk_i);
      #1;
      if (sec_tick_o) ticks++;
    end
    check("s86399_no_early_tick", ticks, 0);
    check_tod("s86399_pre", 23, 59, 59);
    @(posedge clk_i);
    #1;
    check("s86399_posix", posix_time_o, 86400);
    check("s86399_sec_tick", 32'(sec_tick_o), 1);
    check("s86399_day_tick", 32'(day_tick_o), 1);
    check_tod("s86399_post", 0, 0, 0);
    @(posedge clk_i);
    #1;
    check("s86399_sec_tick_one_cycle", 32'(sec_tick_o), 0);
    check("s86399_day_tick_one_cycle", 32'(day_tick_o), 0);

    // Set 0xFFFFFFFF -> 06:28:15, wraps to 0 and time-of-day keeps counting.
    @(negedge clk_i);
    apply_set("smax", 32'hFFFF_FFFF);
    repeat (F - 1) begin
      @(posedge clk_i);
      #1;
    end
    check("smax_pre_posix", posix_time_o, 32'hFFFF_FFFF);
    check("smax_pre_valid", 32'(tod_valid_o), 1);
    check_tod("smax_pre", 6, 28, 15);
    @(posedge clk_i);
    #1;
    check("smax_wrap_posix", posix_time_o, 0);
    check("smax_wrap_sec_tick", 32'(sec_tick_o), 1);
    check("smax_wrap_day_tick", 32'(day_tick_o), 0);
    check_tod("smax_post", 6, 28, 16);

    // set_valid held through a conversion is taken once ready returns.
    @(negedge clk_i);
    apply_set("hold_first", 32'd1700000000);
    set_valid_i = 1'b1;
    set_time_i  = 32'd3661;
    got = 0;
    for (int k = 0; k < 300 && got == 0; k++) begin
      @(posedge clk_i);
      #1;
      if (set_ready_o) got = 1;
    end
    check("hold_ready_returns", got, 1);
    check("hold_ignored_while_busy", posix_time_o, 32'd1700000000);
    check_tod("hold_first", 22, 13, 20);
    @(posedge clk_i);
    #1;
    check("hold_accepted", posix_time_o, 32'd3661);
    check("hold_ready_low", 32'(set_ready_o), 0);
    @(negedge clk_i);
    set_valid_i = 1'b0;
    wait_tod_valid("hold");
    check_tod("hold", 1, 1, 1);

    // Set presented on the terminal-count cycle: load wins, no tick.
    @(negedge clk_i);
    apply_set("tc_base", 32'd1000);
    repeat (F - 1) @(negedge clk_i);
    check("tc_base_posix", posix_time_o, 32'd1000);
    check_tod("tc_base", 0, 16, 40);
    apply_set("tc_set", 32'd5000);
    wait_tod_valid("tc_set");
    check("tc_set_posix_unincremented", posix_time_o, 32'd5000);
    check_tod("tc_set", 1, 23, 20);

    // Reset in the middle of the divide.
    @(negedge clk_i);
    apply_set("rst_mid", 32'd12345);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rst_mid_posix", posix_time_o, 0);
    check("rst_mid_ready", 32'(set_ready_o), 1);
    check("rst_mid_tod_valid", 32'(tod_valid_o), 1);
    check_tod("rst_mid", 0, 0, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    ticks = 0;
    for (int k = 1; k <= F; k++) begin
      @(posedge clk_i);
      #1;
      if (sec_tick_o) ticks++;
    end
    check("rst_mid_ticks", ticks, 1);
    check("rst_mid_after_posix", posix_time_o, 1);
    check_tod("rst_mid_after", 0, 0, 1);

    @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/posix_time_counter.md
Name: posix_time_counter

Overview:
- Upstream stage of the calendar path: keeps free-running POSIX seconds and drives `posix_time_i` of the date-conversion stage.
- Derives a 1 Hz tick from the system clock with a prescaler.
- Maintains a time-of-day breakdown (hh:mm:ss) alongside the seconds count.
- Accepts a new time through a valid/ready set port and rebuilds hh:mm:ss with a multi-cycle divide FSM.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clock cycles per second. Must be >= 128; elaboration error otherwise.

Ports:
- clk_i, input, 1, system clock.
- rst_i, input, 1, reset; asynchronous, active-high.
- set_valid_i, input, 1, set request.
- set_time_i, input, 32, POSIX seconds to load.
- set_ready_o, output, 1, set request can be accepted.
- posix_time_o, output, 32, current POSIX seconds; feeds posix_time_to_date.
- sec_tick_o, output, 1, one-cycle pulse when posix_time_o increments.
- day_tick_o, output, 1, one-cycle pulse when time-of-day wraps to 00:00:00.
- hour_o, output, 5, hours 0..23.
- min_o, output, 6, minutes 0..59.
- sec_o, output, 6, seconds 0..59.
- tod_valid_o, output, 1, hour_o/min_o/sec_o are consistent with posix_time_o.

Behaviour:
- Reset values (async on rst_i):
  - posix_time_o=0, hour_o/min_o/sec_o=0, prescaler=0, state=IDLE.
  - sec_tick_o=0, day_tick_o=0.
  - set_ready_o=1, tod_valid_o=1 (epoch is 00:00:00).
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1 and wraps.
  - Terminal count in IDLE, with no set accepted: next cycle posix_time_o+1 (mod 2^32) and sec_tick_o=1 for exactly one cycle.
  - Time-of-day advances in the same cycle: sec 59->0 carries min, min 59->0 carries hour, 23:59:59 -> 00:00:00 with day_tick_o=1 in the same cycle as sec_tick_o.
- posix_time_o wrap:
  - 0xFFFFFFFF -> 0.
  - Time-of-day simply continues counting; it is not resynchronised to 00:00:00.
- Set handshake:
  - Accepted when set_valid_i & set_ready_o at edge N.
  - At N+1: posix_time_o=set_time_i, prescaler=0, set_ready_o=0, tod_valid_o=0, sec_tick_o=0.
  - Set wins over a simultaneous terminal count; that tick is dropped.
- FSM IDLE -> DIV -> HRS -> MINS -> IDLE:
  - DIV: 32-cycle restoring division of the loaded value by 86400 (cycles N+1..N+32). Keeps the remainder sod (17 bits).
  - HRS: subtract 3600 per cycle while rem >= 3600, counting H. Occupies H+1 cycles.
  - MINS: subtract 60 per cycle while rem >= 60, counting M. Occupies M+1 cycles. The last MINS cycle registers hour_o=H, min_o=M, sec_o=rem and returns to IDLE.
  - Latency: tod_valid_o=1 and set_ready_o=1 from cycle N+35+H+M. Worst case is N+117.
- During conversion:
  - hour_o/min_o/sec_o hold their old values.
  - No tick can occur: prescaler restarted at load and CLK_FREQ_HZ >= 128.
  - set_valid_i is ignored; the requester holds it, and it is accepted once ready returns.
  - set_time_i is sampled only at acceptance.
- Reset mid-conversion: immediate return to reset values; the partial result is discarded.

Decomposition:
- Shared package date_pkg holds:
  - SEC_IN_DAY=86400, SEC_IN_HOUR=3600, SEC_IN_MIN=60.
  - HOUR_W=5, MIN_W=6, SEC_W=6.
  - Enum tod_conv_state_t {IDLE, DIV, HRS, MINS}.
- Sub-module sec_of_day_div: sequential 32-bit by 17-bit restoring-division remainder unit.
  - Interface: start, dividend, done, rem.
  - Reusable by the alarm compare path.
- Prescaler, carry chain and FSM stay in the top module.

Test Plan (CLK_FREQ_HZ=200):
- Reset, then run 3*200 cycles -> posix_time_o=3, sec_o=3, exactly 3 sec_tick_o pulses spaced 200 cycles apart, tod_valid_o=1 throughout.
- Set 1700000000 at edge N -> posix_time_o=1700000000 at N+1; hour_o=22, min_o=13, sec_o=20 with tod_valid_o rising at exactly N+70; set_ready_o low N+1..N+69.
- Set 86399, wait 200 cycles -> posix_time_o=86400, 00:00:00, sec_tick_o and day_tick_o high together for one cycle.
- Set 0xFFFFFFFF, wait for tod_valid_o, then 200 cycles:
  - Before the tick: 06:28:15.
  - After the tick: posix_time_o=0, time 06:28:16, no day_tick_o.
- set_valid_i held during a conversion with set_time_i=3661 -> ignored until set_ready_o=1, then accepted; final 01:01:01.
- Set presented on the prescaler terminal-count cycle -> no sec_tick_o, loaded value unincremented.
- rst_i asserted mid-DIV -> all outputs at reset values, FSM IDLE.
